// File: rtl/scfifo_model.sv
// Single-clock FIFO with show-ahead or registered output, count-decoded flags,
// asynchronous active-low clear and synchronous flush.
module scfifo_model #(
   parameter int unsigned lpm_width          = 64,
   parameter int unsigned lpm_numwords       = 4,
   parameter int unsigned almost_full_value  = lpm_numwords,
   parameter int unsigned almost_empty_value = 2,
   parameter string       lpm_showahead      = "ON"
) (
   input  logic                 clock,
   input  logic                 aclr,
   input  logic                 sclr,
   input  logic [lpm_width-1:0] data,
   input  logic                 wrreq,
   input  logic                 rdreq,
   output logic [lpm_width-1:0] q,
   output logic                 full,
   output logic                 almost_full,
   output logic                 empty,
   output logic                 almost_empty
);

   localparam int unsigned AW = (lpm_numwords > 1) ? $clog2(lpm_numwords) : 1;
   localparam logic [AW:0] DEPTH = (AW+1)'(lpm_numwords);
   localparam logic [AW:0] AFV   = (AW+1)'(almost_full_value);
   localparam logic [AW:0] AEV   = (AW+1)'(almost_empty_value);

   logic [lpm_width-1:0] mem_q [lpm_numwords];
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]          count_q, count_d;
   logic                 wr_en, rd_en;

   assign full         = (count_q == DEPTH);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFV);
   assign almost_empty = (count_q < AEV);

   assign wr_en = wrreq & ~full;
   assign rd_en = rdreq & ~empty;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (sclr) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge aclr) begin
      if (!aclr) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left out of the clear domain.
   always_ff @(posedge clock) begin
      if (aclr && !sclr && wr_en) mem_q[wr_ptr_q] <= data;
   end

   generate
      if (lpm_showahead == "ON") begin : g_showahead
         assign q = empty ? '0 : mem_q[rd_ptr_q];
      end else begin : g_registered
         logic [lpm_width-1:0] q_reg_q;

         always_ff @(posedge clock or negedge aclr) begin
            if (!aclr)              q_reg_q <= '0;
            else if (!sclr && rd_en) q_reg_q <= mem_q[rd_ptr_q];
         end

         assign q = q_reg_q;
      end
   endgenerate

endmodule

// File: tb/tb_scfifo_model.sv
// Randomized and directed bench for scfifo_model: a show-ahead instance and a
// registered-output instance share stimulus and are checked against a queue model.
module tb_scfifo_model;

   localparam int unsigned W = 8;

   logic         clock = 1'b0;
   logic         aclr  = 1'b0;
   logic         sclr  = 1'b0;
   logic [W-1:0] data  = '0;
   logic         wrreq = 1'b0;
   logic         rdreq = 1'b0;

   logic [W-1:0] q_on, q_off;
   logic         full_on, afull_on, empty_on, aempty_on;
   logic         full_off, afull_off, empty_off, aempty_off;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   logic [W-1:0] mq[$];
   logic [W-1:0] off_q_exp = '0;

   always #5 clock = ~clock;

   scfifo_model #(
      .lpm_width(W), .lpm_numwords(4), .almost_full_value(3),
      .almost_empty_value(2), .lpm_showahead("ON")
   ) u_on (
      .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq),
      .rdreq(rdreq), .q(q_on), .full(full_on), .almost_full(afull_on),
      .empty(empty_on), .almost_empty(aempty_on)
   );

   scfifo_model #(
      .lpm_width(W), .lpm_numwords(4), .almost_full_value(4),
      .almost_empty_value(2), .lpm_showahead("OFF")
   ) u_off (
      .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq),
      .rdreq(rdreq), .q(q_off), .full(full_off), .almost_full(afull_off),
      .empty(empty_off), .almost_empty(aempty_off)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      chk("on.q",      32'(q_on),      (n == 0) ? 32'd0 : 32'(mq[0]));
      chk("on.full",   32'(full_on),   32'(n == 4));
      chk("on.empty",  32'(empty_on),  32'(n == 0));
      chk("on.afull",  32'(afull_on),  32'(n >= 3));
      chk("on.aempty", 32'(aempty_on), 32'(n < 2));
      chk("off.q",     32'(q_off),     32'(off_q_exp));
      chk("off.full",  32'(full_off),  32'(n == 4));
      chk("off.empty", 32'(empty_off), 32'(n == 0));
      chk("off.afull", 32'(afull_off), 32'(n >= 4));
      chk("off.aempty",32'(aempty_off),32'(n < 2));
   endtask

   task automatic step(input logic wr, input logic rd, input logic sc, input logic [W-1:0] d);
      bit rd_ok, wr_ok;
      @(negedge clock);
      wrreq = wr; rdreq = rd; sclr = sc; data = d;
      @(posedge clock);
      if (sc) begin
         mq.delete();
      end else begin
         rd_ok = rd && (mq.size() > 0);
         wr_ok = wr && (mq.size() < 4);
         if (rd_ok) off_q_exp = mq.pop_front();
         if (wr_ok) mq.push_back(d);
      end
      #1 check_all();
   endtask

   task automatic async_clear();
      @(negedge clock);
      wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
      #2 aclr = 1'b0;
      #1;
      mq.delete();
      off_q_exp = '0;
      check_all();
      @(negedge clock);
      aclr = 1'b1;
      #1 check_all();
   endtask

   initial begin
      #1 check_all();
      #10 aclr = 1'b1;

      // fill / drain
      step(1, 0, 0, 8'h0A); step(1, 0, 0, 8'h0B);
      step(1, 0, 0, 8'h0C); step(1, 0, 0, 8'h0D);
      step(1, 0, 0, 8'hEE); step(1, 1, 0, 8'hEE);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
      step(0, 1, 0, 8'h00);

      // simultaneous read+write at count 2 across the wrap
      step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22);
      for (int i = 0; i < 10; i++) step(1, 1, 0, 8'h30 + 8'(i));

      // async clear at count 3
      step(1, 0, 0, 8'h55);
      async_clear();
      step(1, 0, 0, 8'h77);
      step(0, 1, 0, 8'h00);

      // flush at count 3 with both requests
      step(1, 0, 0, 8'h01); step(1, 0, 0, 8'h02); step(1, 0, 0, 8'h03);
      step(1, 1, 1, 8'h99);
      step(1, 0, 0, 8'h05);
      step(0, 1, 0, 8'h00);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) async_clear();
         else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 39) == 0), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
